button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
// PURPOSE
//   Conditions one raw board push-button (active-low, asynchronous, bouncy).
//   Produces a clean pressed level, one-cycle press/release pulses and a long-press event.
//   Sits upstream of the LED counter stage: ~btn_level_o drives its active-low rst,
//   and the pulses serve as step/mode events for neighbouring logic.
// PARAMETERS
//   SYNC_STAGES   2         flops in the input synchroniser chain (>=2)
//   STABLE_COUNT  270000    cycles the synced input must hold a new level (10 ms @ 27 MHz, >=2)
//   LONG_COUNT    27000000  cycles after press_pulse_o before long-press fires (1 s, >STABLE_COUNT)
// PORTS
//   clk              in   1  system clock; single clock domain
//   rst              in   1  synchronous, active-low reset
//   btn_n_i          in   1  raw button, 0 = pressed, asynchronous to clk
//   btn_level_o      out  1  debounced level, 1 = pressed
//   press_pulse_o    out  1  1-cycle strobe on confirmed press
//   release_pulse_o  out  1  1-cycle strobe on confirmed release
//   long_pulse_o     out  1  1-cycle strobe when press held LONG_COUNT cycles
//   long_held_o      out  1  1 from long_pulse_o until confirmed release
// BEHAVIOUR
//   - Widths: stab_cnt = $clog2(STABLE_COUNT+1) bits; hold_cnt = $clog2(LONG_COUNT+1) bits.
//     Both are unsigned, compared with ==, and never wrap.
//   - Reset (rst==0 at posedge):
//     - sync chain = all 1 (released); state = RELEASED; both counters = 0.
//     - All outputs = 0.
//     - Reset wins over every other event.
//   - sync = last synchroniser flop. t0 = first edge at which sync shows the new level.
//   - FSM states: RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK.
//     - RELEASED: sync==0 -> PRESS_CHK, stab_cnt=1; else stay, stab_cnt=0.
//     - PRESS_CHK: sync==1 -> RELEASED, stab_cnt=0 (bounce rejected, no output).
//       - sync==0 and stab_cnt==STABLE_COUNT-1 -> PRESSED: btn_level_o=1, press_pulse_o=1, hold_cnt=0.
//       - otherwise stab_cnt++.
//     - PRESSED: sync==1 -> RELEASE_CHK, stab_cnt=1.
//       - hold_cnt++ every cycle until it reaches LONG_COUNT, then saturates.
//       - The edge where hold_cnt becomes LONG_COUNT: long_pulse_o=1 and long_held_o=1.
//     - RELEASE_CHK: mirror of PRESS_CHK.
//       - sync==0 -> back to PRESSED (bounce), with no pulse.
//       - sync==1 for STABLE_COUNT samples -> RELEASED: btn_level_o=0, release_pulse_o=1, long_held_o=0.
//       - hold_cnt keeps counting here, so a bounce cannot delay or repeat long_pulse_o.
//   - Latency: btn_level_o changes at edge t0+STABLE_COUNT-1 if sync is stable.
//     Raw change to output = SYNC_STAGES+STABLE_COUNT-1 edges.
//   - Pulses are registered, exactly 1 cycle wide, and never overlap.
//     long_pulse_o fires at most once per press.
//   - Release before LONG_COUNT: no long_pulse_o. long_held_o stays 0.
//   - Reset mid-press: outputs drop to 0 immediately and no release_pulse_o is issued.
//     If the button is still held after reset, it requires a full debounce and yields a fresh press_pulse_o.
//   - btn_level_o changes only together with press_pulse_o or release_pulse_o.
// TESTING  (bench: SYNC_STAGES=2, STABLE_COUNT=4, LONG_COUNT=10)
//   1. Clean press: btn_n_i 1->0 before edge e, held low ->
//      btn_level_o and press_pulse_o high at edge e+4; press_pulse_o low at e+5.
//   2. Bounce reject: btn_n_i low 3 cycles then high ->
//      no press_pulse_o, btn_level_o stays 0, FSM back in RELEASED.
//   3. Release with bounce: while pressed, raise btn_n_i, low 1 cycle, then high ->
//      release_pulse_o only after 4 consecutive high sync samples.
//      Exactly one release_pulse_o.
//   4. Long press: hold low -> long_pulse_o exactly 10 cycles after press_pulse_o, single cycle.
//      long_held_o stays 1 until release_pulse_o, then goes 0 on the same edge.
//   5. Short press: release 6 cycles after press_pulse_o -> no long_pulse_o; long_held_o never 1.
//   6. Reset mid-press: assert rst while btn_level_o=1, button still held ->
//      all outputs 0 at next edge, no release_pulse_o.
//      After rst deasserts, press_pulse_o again at release edge + 5.

Source files
------------

// File: rtl/button_debouncer_if.sv
// Button conditioner signal bundle.
// master drives the raw button; slave is the debouncer.
interface button_debouncer_if;
    logic btn_n_i;
    logic btn_level_o;
    logic press_pulse_o;
    logic release_pulse_o;
    logic long_pulse_o;
    logic long_held_o;

    modport master (
        output btn_n_i,
        input  btn_level_o,
        input  press_pulse_o,
        input  release_pulse_o,
        input  long_pulse_o,
        input  long_held_o
    );

    modport slave (
        input  btn_n_i,
        output btn_level_o,
        output press_pulse_o,
        output release_pulse_o,
        output long_pulse_o,
        output long_held_o
    );
endinterface

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchroniser, debounce FSM,
// press/release strobes and long-press detection.
module button_debouncer #(
    parameter int SYNC_STAGES  = 2,
    parameter int STABLE_COUNT = 270000,
    parameter int LONG_COUNT   = 27000000
) (
    input logic               clk,
    input logic               rst,
    button_debouncer_if.slave bus
);
    localparam int SW = $clog2(STABLE_COUNT + 1);
    localparam int HW = $clog2(LONG_COUNT + 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_COUNT - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_COUNT);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_COUNT - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHK,
        PRESSED,
        RELEASE_CHK
    } state_t;

    state_t state, state_nx;

    // The FSM registers form the final synchroniser stage.
    logic [SYNC_STAGES-2:0] sync_q;
    logic sync;

    logic [SW-1:0] stab_cnt, stab_nx;
    logic [HW-1:0] hold_cnt, hold_nx;

    logic level_q, press_q, release_q, long_q, held_q;
    logic level_nx, press_nx, release_nx, long_nx, held_nx;

    assign sync = sync_q[SYNC_STAGES-2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= bus.btn_n_i;
            for (int i = 1; i < SYNC_STAGES - 1; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_comb begin
        state_nx   = state;
        stab_nx    = stab_cnt;
        hold_nx    = hold_cnt;
        level_nx   = level_q;
        held_nx    = held_q;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        long_nx    = 1'b0;

        if (state == PRESSED || state == RELEASE_CHK) begin
            if (hold_cnt != HOLD_MAX) begin
                hold_nx = hold_cnt + 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    long_nx = 1'b1;
                    held_nx = 1'b1;
                end
            end
        end

        unique case (state)
            RELEASED: begin
                hold_nx = '0;
                if (!sync) begin
                    state_nx = PRESS_CHK;
                    stab_nx  = SW'(1);
                end else begin
                    stab_nx = '0;
                end
            end
            PRESS_CHK: begin
                hold_nx = '0;
                if (sync) begin
                    state_nx = RELEASED;
                    stab_nx  = '0;
                end else if (stab_cnt == STAB_LAST) begin
                    state_nx = PRESSED;
                    stab_nx  = '0;
                    level_nx = 1'b1;
                    press_nx = 1'b1;
                end else begin
                    stab_nx = stab_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (sync) begin
                    state_nx = RELEASE_CHK;
                    stab_nx  = SW'(1);
                end
            end
            RELEASE_CHK: begin
                if (!sync) begin
                    state_nx = PRESSED;
                    stab_nx  = '0;
                end else if (stab_cnt == STAB_LAST) begin
                    // Release wins a tie with long-press so strobes never overlap.
                    state_nx   = RELEASED;
                    stab_nx    = '0;
                    hold_nx    = '0;
                    level_nx   = 1'b0;
                    release_nx = 1'b1;
                    long_nx    = 1'b0;
                    held_nx    = 1'b0;
                end else begin
                    stab_nx = stab_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = RELEASED;
                stab_nx  = '0;
                hold_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RELEASED;
            stab_cnt  <= '0;
            hold_cnt  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state     <= state_nx;
            stab_cnt  <= stab_nx;
            hold_cnt  <= hold_nx;
            level_q   <= level_nx;
            press_q   <= press_nx;
            release_q <= release_nx;
            long_q    <= long_nx;
            held_q    <= held_nx;
        end
    end

    assign bus.btn_level_o     = level_q;
    assign bus.press_pulse_o   = press_q;
    assign bus.release_pulse_o = release_q;
    assign bus.long_pulse_o    = long_q;
    assign bus.long_held_o     = held_q;
endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (STABLE_COUNT=4, LONG_COUNT=10).
// Output vector order: {level, press, release, long, held}.
`timescale 1ns/1ps
module tb_button_debouncer;
    logic clk = 1'b0;
    logic rst;

    button_debouncer_if bus ();

    button_debouncer #(
        .SYNC_STAGES (2),
        .STABLE_COUNT(4),
        .LONG_COUNT  (10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errors  = 0;
    int checks  = 0;
    int press_cnt   = 0;
    int release_cnt = 0;
    int long_cnt    = 0;
    int held_cnt    = 0;
    int level_cnt   = 0;
    int overlap_cnt = 0;

    logic [4:0] outs;
    assign outs = {bus.btn_level_o, bus.press_pulse_o,
                   bus.release_pulse_o, bus.long_pulse_o,
                   bus.long_held_o};

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            press_cnt   += bus.press_pulse_o   ? 1 : 0;
            release_cnt += bus.release_pulse_o ? 1 : 0;
            long_cnt    += bus.long_pulse_o    ? 1 : 0;
            held_cnt    += bus.long_held_o     ? 1 : 0;
            level_cnt   += bus.btn_level_o     ? 1 : 0;
            if ((bus.press_pulse_o ? 1 : 0) + (bus.release_pulse_o ? 1 : 0)
                + (bus.long_pulse_o ? 1 : 0) > 1)
                overlap_cnt++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.btn_n_i = 1'b1;
        step(3);
        checks++;
        if (outs !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outs: got %b want %b", outs, 5'b00000);
        end
        rst = 1'b1;
        step(3);
        checks++;
        if (outs !== 5'b00000) begin
            errors++;
            $display("FAIL idle_outs: got %b want %b", outs, 5'b00000);
        end
    endtask

    task automatic test_clean_press;
        int p0;
        p0 = press_cnt;
        bus.btn_n_i = 1'b0;
        step(4);
        checks++;
        if (outs !== 5'b00000) begin
            errors++;
            $display("FAIL press_early: got %b want %b", outs, 5'b00000);
        end
        step(1);
        checks++;
        if (outs !== 5'b11000) begin
            errors++;
            $display("FAIL press_edge: got %b want %b", outs, 5'b11000);
        end
        step(1);
        checks++;
        if (outs !== 5'b10000) begin
            errors++;
            $display("FAIL press_after: got %b want %b", outs, 5'b10000);
        end
        checks++;
        if (press_cnt - p0 !== 1) begin
            errors++;
            $display("FAIL press_count: got %0d want 1", press_cnt - p0);
        end
    endtask

    task automatic test_release_bounce;
        int r0, g0;
        r0 = release_cnt;
        g0 = long_cnt;
        bus.btn_n_i = 1'b1;
        step(1);
        bus.btn_n_i = 1'b0;
        step(1);
        bus.btn_n_i = 1'b1;
        step(4);
        checks++;
        if (outs !== 5'b10000) begin
            errors++;
            $display("FAIL release_early: got %b want %b", outs, 5'b10000);
        end
        step(1);
        checks++;
        if (outs !== 5'b00100) begin
            errors++;
            $display("FAIL release_edge: got %b want %b", outs, 5'b00100);
        end
        step(3);
        checks++;
        if (outs !== 5'b00000) begin
            errors++;
            $display("FAIL release_after: got %b want %b", outs, 5'b00000);
        end
        checks++;
        if (release_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL release_count: got %0d want 1", release_cnt - r0);
        end
        checks++;
        if (long_cnt - g0 !== 0) begin
            errors++;
            $display("FAIL release_nolong: got %0d want 0", long_cnt - g0);
        end
    endtask

    task automatic test_bounce_reject;
        int p0, l0;
        p0 = press_cnt;
        l0 = level_cnt;
        bus.btn_n_i = 1'b0;
        step(3);
        bus.btn_n_i = 1'b1;
        step(6);
        checks++;
        if (press_cnt - p0 !== 0 || level_cnt - l0 !== 0) begin
            errors++;
            $display("FAIL bounce_press: got %0d/%0d want 0/0",
                     press_cnt - p0, level_cnt - l0);
        end
        bus.btn_n_i = 1'b0;
        step(4);
        checks++;
        if (outs !== 5'b00000) begin
            errors++;
            $display("FAIL bounce_relatch_early: got %b want %b", outs, 5'b00000);
        end
        step(1);
        checks++;
        if (outs !== 5'b11000) begin
            errors++;
            $display("FAIL bounce_relatch: got %b want %b", outs, 5'b11000);
        end
        bus.btn_n_i = 1'b1;
        step(6);
        checks++;
        if (outs !== 5'b00000) begin
            errors++;
            $display("FAIL bounce_release: got %b want %b", outs, 5'b00000);
        end
    endtask

    task automatic test_long_press;
        int g0;
        g0 = long_cnt;
        bus.btn_n_i = 1'b0;
        step(5);
        checks++;
        if (outs !== 5'b11000) begin
            errors++;
            $display("FAIL long_press: got %b want %b", outs, 5'b11000);
        end
        step(9);
        checks++;
        if (outs !== 5'b10000 || long_cnt - g0 !== 0) begin
            errors++;
            $display("FAIL long_early: got %b/%0d want %b/0",
                     outs, long_cnt - g0, 5'b10000);
        end
        step(1);
        checks++;
        if (outs !== 5'b10011) begin
            errors++;
            $display("FAIL long_edge: got %b want %b", outs, 5'b10011);
        end
        step(1);
        checks++;
        if (outs !== 5'b10001) begin
            errors++;
            $display("FAIL long_after: got %b want %b", outs, 5'b10001);
        end
        step(5);
        bus.btn_n_i = 1'b1;
        step(4);
        checks++;
        if (outs !== 5'b10001) begin
            errors++;
            $display("FAIL long_held: got %b want %b", outs, 5'b10001);
        end
        step(1);
        checks++;
        if (outs !== 5'b00100) begin
            errors++;
            $display("FAIL long_release: got %b want %b", outs, 5'b00100);
        end
        checks++;
        if (long_cnt - g0 !== 1) begin
            errors++;
            $display("FAIL long_count: got %0d want 1", long_cnt - g0);
        end
        step(2);
    endtask

    task automatic test_short_press;
        int g0, h0, r0;
        g0 = long_cnt;
        h0 = held_cnt;
        r0 = release_cnt;
        bus.btn_n_i = 1'b0;
        step(5);
        checks++;
        if (outs !== 5'b11000) begin
            errors++;
            $display("FAIL short_press: got %b want %b", outs, 5'b11000);
        end
        step(1);
        bus.btn_n_i = 1'b1;
        step(4);
        checks++;
        if (outs !== 5'b10000) begin
            errors++;
            $display("FAIL short_early: got %b want %b", outs, 5'b10000);
        end
        step(1);
        checks++;
        if (outs !== 5'b00100) begin
            errors++;
            $display("FAIL short_release: got %b want %b", outs, 5'b00100);
        end
        step(12);
        checks++;
        if (long_cnt - g0 !== 0 || held_cnt - h0 !== 0) begin
            errors++;
            $display("FAIL short_nolong: got %0d/%0d want 0/0",
                     long_cnt - g0, held_cnt - h0);
        end
        checks++;
        if (release_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL short_rel_count: got %0d want 1", release_cnt - r0);
        end
    endtask

    task automatic test_reset_mid_press;
        int r0, p0;
        bus.btn_n_i = 1'b0;
        step(5);
        checks++;
        if (outs !== 5'b11000) begin
            errors++;
            $display("FAIL midrst_press: got %b want %b", outs, 5'b11000);
        end
        step(2);
        r0 = release_cnt;
        rst = 1'b0;
        step(1);
        checks++;
        if (outs !== 5'b00000) begin
            errors++;
            $display("FAIL midrst_outs: got %b want %b", outs, 5'b00000);
        end
        step(1);
        rst = 1'b1;
        p0 = press_cnt;
        step(4);
        checks++;
        if (outs !== 5'b00000) begin
            errors++;
            $display("FAIL midrst_early: got %b want %b", outs, 5'b00000);
        end
        step(1);
        checks++;
        if (outs !== 5'b11000) begin
            errors++;
            $display("FAIL midrst_repress: got %b want %b", outs, 5'b11000);
        end
        checks++;
        if (release_cnt - r0 !== 0 || press_cnt - p0 !== 1) begin
            errors++;
            $display("FAIL midrst_counts: got rel=%0d press=%0d want 0/1",
                     release_cnt - r0, press_cnt - p0);
        end
        bus.btn_n_i = 1'b1;
        step(6);
        checks++;
        if (outs !== 5'b00000) begin
            errors++;
            $display("FAIL midrst_release: got %b want %b", outs, 5'b00000);
        end
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 3; k++) begin
            bus.btn_n_i = 1'b0;
            step(5);
            checks++;
            if (outs !== 5'b11000) begin
                errors++;
                $display("FAIL b2b_press%0d: got %b want %b", k, outs, 5'b11000);
            end
            bus.btn_n_i = 1'b1;
            step(5);
            checks++;
            if (outs !== 5'b00100) begin
                errors++;
                $display("FAIL b2b_release%0d: got %b want %b", k, outs, 5'b00100);
            end
        end
        checks++;
        if (overlap_cnt !== 0) begin
            errors++;
            $display("FAIL pulse_overlap: got %0d want 0", overlap_cnt);
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.btn_n_i = 1'b1;
        test_reset();
        test_clean_press();
        test_release_bounce();
        test_bounce_reject();
        test_long_press();
        test_short_press();
        test_reset_mid_press();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
